// File: rtl/isu_scoreboard_n.sv
// Issue scoreboard: per-register saturating pending-writer counters, RAW
// resolution by byte-merged forwarding from the FU result ports, and
// single-instruction dispatch to one of NFU functional units per cycle.
module isu_scoreboard_n #(
  parameter int NFU    = 4,
  parameter int NREG   = 72,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2,
  parameter int RB     = $clog2(NREG),
  parameter int FB     = $clog2(NFU)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FB-1:0]           in_fu,
  input  logic [RB-1:0]           in_src1,
  input  logic [RB-1:0]           in_src2,
  input  logic [RB-1:0]           in_dst,
  input  logic [DATA_W-1:0]       in_src1_val,
  input  logic [DATA_W-1:0]       in_src2_val,
  output logic [NFU-1:0]          out_valid,
  input  logic [NFU-1:0]          out_ready,
  output logic [DATA_W-1:0]       out_src1_val,
  output logic [DATA_W-1:0]       out_src2_val,
  input  logic [NFU-1:0]          fwd_valid,
  input  logic [NFU*RB-1:0]       fwd_dst,
  input  logic [NFU*DATA_W-1:0]   fwd_data,
  input  logic [NFU*DATA_W/8-1:0] fwd_bwen,
  input  logic [NFU-1:0]          wb_valid,
  input  logic [NFU*RB-1:0]       wb_dst,
  input  logic                    flush,
  output logic [31:0]             stall_cnt
);

  localparam int NB = DATA_W / 8;
  // Width of the per-register writeback count and of the inc/dec arithmetic.
  localparam int DW = $clog2(NFU + 1);
  localparam int SW = CNT_W + DW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic              hazard;
    logic [DATA_W-1:0] val;
  } res_t;

  logic [CNT_W-1:0] pend_q [NREG];
  logic [CNT_W-1:0] pend_d [NREG];
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic [CNT_W-1:0] pend_s1, pend_s2, pend_dst;
  res_t             res1, res2;
  logic             struct_stall, go, fire, underflow;

  // Resolve one source operand: regfile value, byte-merged forward, or hazard.
  // The lowest-numbered FU with a matching forward wins.
  function automatic res_t resolve(
    input logic [RB-1:0]         src,
    input logic [DATA_W-1:0]     rf_val,
    input logic [CNT_W-1:0]      pend,
    input logic [NFU-1:0]        fv,
    input logic [NFU*RB-1:0]     fd,
    input logic [NFU*DATA_W-1:0] fdat,
    input logic [NFU*NB-1:0]     fbw
  );
    res_t              res;
    logic              hit;
    logic [DATA_W-1:0] hdata;
    logic [NB-1:0]     hbwen;
    res.hazard = 1'b0;
    res.val    = rf_val;
    hit        = 1'b0;
    hdata      = '0;
    hbwen      = '0;
    for (int k = NFU - 1; k >= 0; k--) begin
      if (fv[k] && (fd[k*RB +: RB] == src)) begin
        hit   = 1'b1;
        hdata = fdat[k*DATA_W +: DATA_W];
        hbwen = fbw[k*NB +: NB];
      end
    end
    if ((src != '0) && (pend != '0)) begin
      if ((pend == CNT_ONE) && hit) begin
        for (int b = 0; b < NB; b++) begin
          if (hbwen[b]) res.val[b*8 +: 8] = hdata[b*8 +: 8];
        end
      end else begin
        res.hazard = 1'b1;
      end
    end
    return res;
  endfunction

  // Look up the pending counts of both sources and the destination.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    pend_s1  = '0;
    pend_s2  = '0;
    pend_dst = '0;
    for (int r = 1; r < NREG; r++) begin
      if (in_src1 == RB'(r)) pend_s1  = pend_q[r];
      if (in_src2 == RB'(r)) pend_s2  = pend_q[r];
      if (in_dst  == RB'(r)) pend_dst = pend_q[r];
    end
  end

  // Operand resolution, issue decision and handshake (zero latency).
  always_comb begin
    res1         = resolve(in_src1, in_src1_val, pend_s1, fwd_valid, fwd_dst, fwd_data, fwd_bwen);
    res2         = resolve(in_src2, in_src2_val, pend_s2, fwd_valid, fwd_dst, fwd_data, fwd_bwen);
    struct_stall = (in_dst != '0) && (pend_dst == CNT_MAX);
    go           = in_valid && !flush && !res1.hazard && !res2.hazard && !struct_stall;
    out_valid    = go ? (NFU'(1) << in_fu) : '0;
    fire         = |(out_valid & out_ready);
    in_ready     = fire || !in_valid || flush;
    out_src1_val = res1.val;
    out_src2_val = res2.val;
  end

  // Next pending counts: net of one issue and any number of writebacks;
  // flush clears everything, register 0 is never tracked.
  always_comb begin
    logic [SW-1:0] sum;
    logic [SW-1:0] dec;
    underflow = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      dec = '0;
      for (int k = 0; k < NFU; k++) begin
        if (wb_valid[k] && (wb_dst[k*RB +: RB] == RB'(r))) dec = dec + SW'(1);
      end
      sum = SW'(pend_q[r]) + SW'(fire && (in_dst == RB'(r)));
      if (flush || (r == 0)) begin
        pend_d[r] = '0;
      end else if (sum < dec) begin
        pend_d[r] = '0;
        underflow = 1'b1;
      end else if ((sum - dec) > SW'(CNT_MAX)) begin
        pend_d[r] = CNT_MAX;
      end else begin
        pend_d[r] = CNT_W'(sum - dec);
      end
    end
    stall_cnt_d = stall_cnt_q + 32'(in_valid && !in_ready && !flush);
  end

  // State registers with asynchronous clear.
  // NOTE: the counter array is reset because it is control state, not data storage;
  // NOTE: sequential state uses non-blocking assignment only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // A writeback to a register with no pending writer indicates an upstream bug.
  assert property (@(posedge clk) disable iff (!rst_n) !underflow)
    else $error("isu_scoreboard_n: writeback to a register with no pending writer");

endmodule
